smem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port shared-memory interface among `N_PROC` SIMD processing elements. Each PE raises a read or write request and holds it while it owns the bus. The arbiter grants one PE at a time and muxes that PE's address, write data and write size onto the memory port. Read data is broadcast to all PEs. It sits between the PE array and the shared memory, and is the sole source of every PE's `grant_rd`/`grant_wr`.

---
 rtl/smem_arbiter_pkg.sv | 22 ++
 rtl/smem_arbiter_rr_pick.sv | 34 +++
 rtl/smem_arbiter.sv | 122 ++++++++++++
 tb/tb_smem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_arbiter_pkg.sv
// Shared types for the shared-memory arbiter: bus geometry, access type and FSM encoding.
package smem_arbiter_pkg;

    localparam int USIZE     = 16;
    localparam int MAX_ELEMS = 5;
    localparam int BUS_W     = USIZE * MAX_ELEMS;
    localparam int ADDR_BITS = 16;

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_type_e;

    typedef logic [1:0] arb_state_e;

    localparam arb_state_e ST_IDLE    = 2'd0;
    localparam arb_state_e ST_OWN     = 2'd1;
    localparam arb_state_e ST_RELEASE = 2'd2;

endpackage

// File: rtl/smem_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_PROC = 4,
    parameter int PTR_W  = $clog2(N_PROC)
) (
    input  logic [N_PROC-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [PTR_W-1:0]  idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] pos;

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        for (int off = N_PROC - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(N_PROC)) begin
                sum = sum - (PTR_W + 1)'(N_PROC);
            end
            pos = sum[PTR_W-1:0];
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/smem_arbiter.sv
// Round-robin owner arbiter for one single-port shared memory shared by N_PROC PEs.
module smem_arbiter
    import smem_arbiter_pkg::*;
#(
    parameter int N_PROC   = 4,
    parameter int ADDR_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [N_PROC-1:0]         i_req_rd,
    input  logic [N_PROC-1:0]         i_req_wr,
    input  logic [N_PROC*ADDR_W-1:0]  i_addr,
    input  logic [N_PROC*BUS_W-1:0]   i_wdata,
    input  logic [N_PROC*3-1:0]       i_wr_size,
    output logic [N_PROC-1:0]         o_grant_rd,
    output logic [N_PROC-1:0]         o_grant_wr,
    output logic [BUS_W-1:0]          o_rdata,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [BUS_W-1:0]          o_mem_wdata,
    output logic [2:0]                o_mem_wsize,
    input  logic [BUS_W-1:0]          i_mem_rdata,
    output logic [1:0]                o_dbg_state,
    output logic [$clog2(N_PROC)-1:0] o_dbg_ptr
);

    localparam int PTR_W = $clog2(N_PROC);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e       state;
    arb_type_e        typ;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] hold_cnt;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic             own_req;
    logic             owning;
    logic [PTR_W-1:0] owner_next;

    rr_pick #(
        .N_PROC (N_PROC),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req   (i_req_rd | i_req_wr),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_req    = (typ == ARB_WR) ? i_req_wr[owner] : i_req_rd[owner];
    assign owning     = (state == ST_OWN);
    assign owner_next = (owner == PTR_W'(N_PROC - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            typ      <= ARB_RD;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        typ      <= arb_type_e'(i_req_wr[pick_idx]);
                        hold_cnt <= '0;
                        state    <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // A type switch is just a drop: the PE re-competes from IDLE.
                    if (!own_req) begin
                        ptr   <= owner_next;
                        state <= ST_IDLE;
                    end else if (hold_cnt >= CNT_W'(MAX_HOLD - 2)) begin
                        // hold_cnt is about to reach MAX_HOLD-1: cap the tenure.
                        ptr   <= owner_next;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Grants decode registered state only; the live request gates just the memory strobe.
    always_comb begin
        o_grant_rd = '0;
        o_grant_wr = '0;
        if (owning) begin
            if (typ == ARB_WR) o_grant_wr[owner] = 1'b1;
            else               o_grant_rd[owner] = 1'b1;
        end
    end

    always_comb begin
        o_mem_en    = owning && own_req;
        o_mem_we    = owning && (typ == ARB_WR);
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wsize = '0;
        if (o_mem_en) begin
            o_mem_addr  = i_addr[int'(owner)*ADDR_W +: ADDR_W];
            o_mem_wdata = i_wdata[int'(owner)*BUS_W +: BUS_W];
            o_mem_wsize = i_wr_size[int'(owner)*3 +: 3];
        end
    end

    assign o_rdata     = i_mem_rdata;
    assign o_dbg_state = state;
    assign o_dbg_ptr   = ptr;

endmodule

// File: tb/tb_smem_arbiter.sv
// Scenario bench for smem_arbiter with a scoreboard of expected memory accesses.
module tb_smem_arbiter;
    import smem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int MH = 4;
    localparam int EW = 1 + 3 + AW + BUS_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      req_rd = '0;
    logic [N-1:0]      req_wr = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*BUS_W-1:0] wdata = '0;
    logic [N*3-1:0]    wsize = '0;
    logic [BUS_W-1:0]  mem_rdata = '0;

    logic [N-1:0]      grant_rd, grant_wr;
    logic [BUS_W-1:0]  rdata, mem_wdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [2:0]        mem_wsize;
    logic [1:0]        dbg_state;
    logic [1:0]        dbg_ptr;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_e, want_e;
    int total = 0;
    int bad   = 0;

    smem_arbiter #(.N_PROC(N), .ADDR_W(AW), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_addr(addr), .i_wdata(wdata), .i_wr_size(wsize),
        .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wsize(mem_wsize), .i_mem_rdata(mem_rdata),
        .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] exp_entry(int k, logic we);
        return {we, wsize[k*3 +: 3], addr[k*AW +: AW], wdata[k*BUS_W +: BUS_W]};
    endfunction

    // Every access the DUT performs must match the next expected access.
    always @(negedge clk) begin
        if (rstn) begin
            total++;
            if (rdata !== mem_rdata) begin
                bad++;
                $display("FAIL rdata_bcast: got %h want %h", rdata, mem_rdata);
            end
            if (mem_en === 1'b1) begin
                total++;
                got_e = {mem_we, mem_wsize, mem_addr, mem_wdata};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL access_unexpected: got we=%b addr=%h want no access", mem_we, mem_addr);
                end else begin
                    want_e = exp_q.pop_front();
                    if (got_e !== want_e) begin
                        bad++;
                        $display("FAIL access: got we=%b size=%0d addr=%h want we=%b size=%0d addr=%h",
                                 got_e[EW-1], got_e[EW-2 -: 3], got_e[EW-5 -: AW],
                                 want_e[EW-1], want_e[EW-2 -: 3], want_e[EW-5 -: AW]);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        mem_rdata = BUS_W'({$urandom, $urandom, $urandom});
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_grants(string name, int c, logic [N-1:0] w_rd, logic [N-1:0] w_wr);
        total++;
        if (grant_rd !== w_rd || grant_wr !== w_wr) begin
            bad++;
            $display("FAIL %s c%0d: got rd=%b wr=%b want rd=%b wr=%b", name, c, grant_rd, grant_wr, w_rd, w_wr);
        end
    endtask

    task automatic check_idle(string name, logic [1:0] w_ptr);
        total++;
        if (dbg_state !== ST_IDLE || dbg_ptr !== w_ptr || grant_rd !== '0 || grant_wr !== '0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_end: got state=%0d ptr=%0d grants=%b/%b pending=%0d want state=0 ptr=%0d grants=0 pending=0",
                     name, dbg_state, dbg_ptr, grant_rd, grant_wr, exp_q.size(), w_ptr);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grant_rd !== '0 || grant_wr !== '0) begin
            bad++; $display("FAIL reset_grants: got %b/%b want 0/0", grant_rd, grant_wr);
        end
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_en_we: got %b/%b want 0/0", mem_en, mem_we);
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_wsize !== '0) begin
            bad++; $display("FAIL reset_mux: got addr=%h size=%0d want 0", mem_addr, mem_wsize);
        end
        total++;
        if (dbg_state !== ST_IDLE || dbg_ptr !== 2'd0) begin
            bad++; $display("FAIL reset_state: got state=%0d ptr=%0d want 0/0", dbg_state, dbg_ptr);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_contention();
        cyc(); req_rd[0] = 1'b1; req_rd[3] = 1'b1;
        exp_q.push_back(exp_entry(0, 1'b0)); exp_q.push_back(exp_entry(0, 1'b0));
        exp_q.push_back(exp_entry(3, 1'b0)); exp_q.push_back(exp_entry(3, 1'b0));
        smp(); check_grants("cont_latency", 1, 4'b0000, 4'b0000);
        for (int c = 2; c <= 3; c++) begin cyc(); smp(); check_grants("cont_pe0", c, 4'b0001, 4'b0000); end
        cyc(); req_rd[0] = 1'b0; smp();
        total++;
        if (mem_en !== 1'b0) begin bad++; $display("FAIL cont_drop_en: got %b want 0", mem_en); end
        cyc(); smp(); check_grants("cont_idle", 5, 4'b0000, 4'b0000);
        for (int c = 6; c <= 7; c++) begin cyc(); smp(); check_grants("cont_pe3", c, 4'b1000, 4'b0000); end
        cyc(); req_rd[3] = 1'b0; smp();
        cyc(); smp(); check_idle("cont", 2'd0);
    endtask

    task automatic test_single_read();
        cyc(); req_rd[2] = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(2, 1'b0));
        smp();
        for (int c = 2; c <= 4; c++) begin
            cyc(); smp(); check_grants("single_grant", c, 4'b0100, 4'b0000);
            total++;
            if (mem_addr !== addr[2*AW +: AW]) begin
                bad++; $display("FAIL single_addr c%0d: got %h want %h", c, mem_addr, addr[2*AW +: AW]);
            end
        end
        cyc(); req_rd[2] = 1'b0; smp();
        cyc(); smp(); check_idle("single", 2'd3);
    endtask

    task automatic test_rw_collision();
        cyc(); req_rd[1] = 1'b1; req_wr[1] = 1'b1;
        exp_q.push_back(exp_entry(1, 1'b1)); exp_q.push_back(exp_entry(1, 1'b1));
        smp();
        for (int c = 2; c <= 3; c++) begin
            cyc(); smp(); check_grants("coll_grant", c, 4'b0000, 4'b0010);
            total++;
            if (mem_we !== 1'b1 || mem_wsize !== 3'd3) begin
                bad++; $display("FAIL coll_we_size c%0d: got we=%b size=%0d want we=1 size=3", c, mem_we, mem_wsize);
            end
        end
        cyc(); req_rd[1] = 1'b0; req_wr[1] = 1'b0; smp();
        cyc(); smp(); check_idle("coll", 2'd2);
    endtask

    task automatic test_forced_release();
        cyc(); req_rd[0] = 1'b1; req_rd[1] = 1'b1;
        for (int i = 0; i < MH - 1; i++) exp_q.push_back(exp_entry(0, 1'b0));
        exp_q.push_back(exp_entry(1, 1'b0));
        smp();
        for (int c = 2; c <= 4; c++) begin cyc(); smp(); check_grants("frel_pe0", c, 4'b0001, 4'b0000); end
        cyc(); smp(); check_grants("frel_release", 5, 4'b0000, 4'b0000);
        total++;
        if (dbg_state !== ST_RELEASE || mem_en !== 1'b0) begin
            bad++; $display("FAIL frel_state: got state=%0d en=%b want state=2 en=0", dbg_state, mem_en);
        end
        cyc(); smp(); check_grants("frel_idle", 6, 4'b0000, 4'b0000);
        total++;
        if (dbg_ptr !== 2'd1) begin bad++; $display("FAIL frel_ptr: got %0d want 1", dbg_ptr); end
        cyc(); smp(); check_grants("frel_pe1", 7, 4'b0010, 4'b0000);
        cyc(); req_rd[0] = 1'b0; req_rd[1] = 1'b0; smp();
        cyc(); smp(); check_idle("frel", 2'd2);
    endtask

    task automatic test_fetch_to_write();
        cyc(); req_rd[0] = 1'b1;
        exp_q.push_back(exp_entry(0, 1'b0)); exp_q.push_back(exp_entry(0, 1'b0));
        exp_q.push_back(exp_entry(0, 1'b1));
        smp();
        for (int c = 2; c <= 3; c++) begin cyc(); smp(); check_grants("f2w_rd", c, 4'b0001, 4'b0000); end
        cyc(); req_rd[0] = 1'b0; req_wr[0] = 1'b1; smp();
        total++;
        if (mem_en !== 1'b0) begin bad++; $display("FAIL f2w_switch_en: got %b want 0", mem_en); end
        cyc(); smp(); check_grants("f2w_idle", 5, 4'b0000, 4'b0000);
        cyc(); smp(); check_grants("f2w_wr", 6, 4'b0000, 4'b0001);
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL f2w_we: got %b want 1", mem_we); end
        cyc(); req_wr[0] = 1'b0; smp();
        cyc(); smp(); check_idle("f2w", 2'd1);
    endtask

    task automatic test_reset_mid_grant();
        cyc(); req_rd[2] = 1'b1;
        exp_q.push_back(exp_entry(2, 1'b0));
        smp();
        cyc(); smp(); check_grants("rmid_grant", 2, 4'b0100, 4'b0000);
        cyc();
        #2 rstn = 1'b0;
        #1;
        check_grants("rmid_async", 3, 4'b0000, 4'b0000);
        total++;
        if (mem_en !== 1'b0 || mem_addr !== '0 || dbg_ptr !== 2'd0 || dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL rmid_outputs: got en=%b addr=%h ptr=%0d state=%0d want 0/0/0/0",
                            mem_en, mem_addr, dbg_ptr, dbg_state);
        end
        req_rd[2] = 1'b0;
        smp();
        rstn = 1'b1;
        cyc(); smp(); check_idle("rmid", 2'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]        = AW'(16'h1000 + k * 16'h0111);
            wdata[k*BUS_W +: BUS_W] = BUS_W'({$urandom, $urandom, $urandom});
            wsize[k*3 +: 3]         = 3'($urandom_range(1, 5));
        end
        wsize[1*3 +: 3] = 3'd3;

        test_reset();
        test_contention();
        test_single_read();
        test_rw_collision();
        test_forced_release();
        test_fetch_to_write();
        test_reset_mid_grant();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
